bcd_seq_converter: RTL and testbench

//  Sequential, parametrised binary-to-BCD converter with a valid/ready handshake on input and output.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_adj.sv | 11 +
 rtl/bcd_seq_converter.sv | 142 ++++++++++++++
 tb/tb_bcd_seq_converter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// The digit adjust rule lives here so every digit slice uses one definition.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam int BCD_DIGIT_W = 4;

  // Double-dabble correction: a digit of 5 or more would exceed 9 after doubling.
  function automatic logic [BCD_DIGIT_W-1:0] add3_adj(input logic [BCD_DIGIT_W-1:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit slice of the double-dabble datapath: combinational >=5 -> +3.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = add3_adj(digit_i);

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative binary-to-BCD converter, one shift per cycle, valid/ready on both sides.
// Define BCD_SIGNED_EN for two's-complement input with a sign output; default is unsigned.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sign,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          out_ovf,
  output bcd_state_t                    dbg_state
);

  // Handshake: a word moves on any rising edge where valid and ready are both high;
  // in_ready is high only in IDLE and out_valid only in DONE, so transfers never overlap.

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  bcd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [BCD_W-1:0] dig_q, dig_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;
  logic             out_sign_q, out_sign_d;
  logic [BCD_W-1:0] out_bcd_q, out_bcd_d;
  logic             out_ovf_q, out_ovf_d;

  logic             in_sign;
  logic [WIDTH-1:0] in_mag;
  logic [BCD_W-1:0] dig_adj;
  logic [BCD_W-1:0] dig_shift;
  logic [WIDTH-1:0] mag_shift;
  logic             shift_carry;

`ifdef BCD_SIGNED_EN
  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    in_sign = in[WIDTH-1];
    in_mag  = in_sign ? (~in + {{(WIDTH-1){1'b0}}, 1'b1}) : in;
  end
`else
  always_comb begin
    in_sign = 1'b0;
    in_mag  = in;
  end
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (dig_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (dig_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign dig_shift   = {dig_adj[BCD_W-2:0], mag_q[WIDTH-1]};
  assign mag_shift   = {mag_q[WIDTH-2:0], 1'b0};
  assign shift_carry = dig_adj[BCD_W-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    dig_d      = dig_q;
    sign_d     = sign_q;
    ovf_d      = ovf_q;
    out_sign_d = out_sign_q;
    out_bcd_d  = out_bcd_q;
    out_ovf_d  = out_ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          mag_d   = in_mag;
          dig_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // WIDTH shifting cycles, then one cycle that registers the finished result.
        if (cnt_q != '0) begin
          dig_d = dig_shift;
          mag_d = mag_shift;
          ovf_d = ovf_q | shift_carry;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          out_sign_d = sign_q;
          out_ovf_d  = ovf_q;
          out_bcd_d  = ovf_q ? '0 : dig_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      dig_q      <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      out_sign_q <= 1'b0;
      out_bcd_q  <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      dig_q      <= dig_d;
      sign_q     <= sign_d;
      ovf_q      <= ovf_d;
      out_sign_q <= out_sign_d;
      out_bcd_q  <= out_bcd_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sign  = out_sign_q;
  assign out_bcd   = out_bcd_q;
  assign out_ovf   = out_ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Bench for bcd_seq_converter: directed corner words, hold/reset cases and random
// back-to-back traffic, all compared against a decimal-arithmetic reference model.
module tb_bcd_seq_converter;
  import bcd_pkg::*;

`ifdef BCD_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 0: WIDTH=5 DIGITS=2 ----------------
  logic       in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic [4:0] in0 = '0;
  logic       in_ready0, out_valid0, out_sign0, out_ovf0;
  logic [7:0] out_bcd0;
  bcd_state_t dbg0;

  bcd_seq_converter #(.WIDTH(5), .DIGITS(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in(in0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_sign(out_sign0),
    .out_bcd(out_bcd0), .out_ovf(out_ovf0), .dbg_state(dbg0)
  );

  // ---------------- DUT a/b: WIDTH=8 with DIGITS=3 and DIGITS=2 ----------------
  logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0]  in8 = '0;
  logic        ready_a, valid_a, sign_a, ovf_a;
  logic        ready_b, valid_b, sign_b, ovf_b;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  bcd_state_t  dbg_a, dbg_b;

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) ua (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(ready_a), .in(in8),
    .out_valid(valid_a), .out_ready(out_ready8), .out_sign(sign_a),
    .out_bcd(bcd_a), .out_ovf(ovf_a), .dbg_state(dbg_a)
  );

  bcd_seq_converter #(.WIDTH(8), .DIGITS(2)) ub (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(ready_b), .in(in8),
    .out_valid(valid_b), .out_ready(out_ready8), .out_sign(sign_b),
    .out_bcd(bcd_b), .out_ovf(ovf_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [13:0] exp_q[$];
  logic [7:0]  last0 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {ovf, sign, bcd[11:0]} from plain decimal arithmetic.
  function automatic logic [13:0] model(input int v, input int w, input int d);
    int          mag, lim;
    bit          s;
    logic [11:0] b;
    s   = SGN && (((v >> (w - 1)) & 1) == 1);
    mag = s ? (1 << w) - v : v;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    if (mag >= lim) return {1'b1, s, 12'h000};
    b = '0;
    for (int i = 0; i < d; i++) begin
      b[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return {1'b0, s, b};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run0(input logic [4:0] v, input int hold);
    logic [13:0] e;
    int          lat;
    e = model(int'(v), 5, 2);
    check("w5_in_ready_idle", in_ready0, 1);
    in0 = v;
    in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    in0 = 5'($urandom);
    check("w5_in_ready_shift", in_ready0, 0);
    lat = 0;
    while (!out_valid0 && lat < 40) begin
      check("w5_bcd_held", out_bcd0, last0);
      step();
      lat++;
    end
    check("w5_latency", lat, 6);
    for (int k = 0; k < hold; k++) begin
      check("w5_hold_valid", out_valid0, 1);
      check("w5_hold_ready", in_ready0, 0);
      check("w5_hold_bcd", out_bcd0, e[7:0]);
      step();
    end
    check("w5_sign", out_sign0, e[12]);
    check("w5_bcd", out_bcd0, e[7:0]);
    check("w5_ovf", out_ovf0, e[13]);
    out_ready0 = 1'b1;
    step();
    out_ready0 = 1'b0;
    check("w5_valid_drop", out_valid0, 0);
    check("w5_back_idle", in_ready0, 1);
    last0 = e[7:0];
  endtask

  task automatic run8(input logic [7:0] v);
    logic [13:0] e3, e2;
    int          lat;
    e3 = model(int'(v), 8, 3);
    e2 = model(int'(v), 8, 2);
    check("w8_ready", {ready_a, ready_b}, 2'b11);
    in8 = v;
    in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    in8 = 8'($urandom);
    lat = 0;
    while (!valid_a && lat < 40) begin
      step();
      lat++;
    end
    check("w8_latency", lat, 9);
    check("w8_valid_b", valid_b, 1);
    check("w8d3_sign", sign_a, e3[12]);
    check("w8d3_bcd", bcd_a, e3[11:0]);
    check("w8d3_ovf", ovf_a, e3[13]);
    check("w8d2_sign", sign_b, e2[12]);
    check("w8d2_bcd", bcd_b, e2[7:0]);
    check("w8d2_ovf", ovf_b, e2[13]);
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int accepted, cycles;
    repeat (3) step();
    rst = 1'b0;
    check("rst_in_ready", in_ready0, 1);
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_sign", out_sign0, 0);
    check("rst_out_bcd", out_bcd0, 0);
    check("rst_out_ovf", out_ovf0, 0);
    check("rst_state", dbg0, IDLE);

    run0(5'b10000, 0);
    run0(5'b01111, 0);
    run0(5'b11111, 0);
    run0(5'b00000, 0);
    run0(5'b10101, 10);

    // Abort in the 3rd shift cycle.
    in0 = 5'b01001;
    in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_valid", out_valid0, 0);
    check("abort_ready", in_ready0, 1);
    check("abort_bcd", out_bcd0, 0);
    last0 = '0;
    for (int k = 0; k < 8; k++) begin
      check("abort_no_result", out_valid0, 0);
      step();
    end
    run0(5'b01011, 0);

    for (int k = 0; k < 6; k++) run0(5'($urandom_range(0, 31)), $urandom_range(0, 3));

    run8(8'h80);
    run8(8'd100);
    run8(8'd99);
    run8(8'hff);
    for (int k = 0; k < 6; k++) run8(8'($urandom));

    // Back-to-back traffic with out_ready held high.
    out_ready0 = 1'b1;
    accepted = 0;
    cycles = 0;
    in0 = 5'($urandom);
    in_valid0 = 1'b1;
    while ((accepted < 20 || exp_q.size() != 0) && cycles < 2000) begin
      if (out_valid0) begin
        if (exp_q.size() == 0) check("b2b_unexpected", 1, 0);
        else begin
          logic [13:0] e;
          e = exp_q.pop_front();
          check("b2b_result", {out_ovf0, out_sign0, out_bcd0}, {e[13], e[12], e[7:0]});
        end
      end
      if (in_valid0 && in_ready0) begin
        exp_q.push_back(model(int'(in0), 5, 2));
        accepted++;
      end
      step();
      cycles++;
      if (accepted >= 20) in_valid0 = 1'b0;
      else if (!in_ready0) in0 = 5'($urandom);
    end
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_count", accepted, 20);
    out_ready0 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
